apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Upstream requester for the team's APB slaves. It accepts single read or write commands on a valid/ready command port. For each command it drives one APB3 transfer: a SETUP phase, then an ACCESS phase, with unlimited wait states and a bounded timeout. It then returns read data and error status on a valid/ready response port. It sits between the local bus fabric and any apb_slave on the same PCLK.

## Interface
Parameters:
- ADDR_W, 32, PADDR/cmd_addr width
- DATA_W, 32, PWDATA/PRDATA/data width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  in  1  single clock, all logic rising-edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid at PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled high, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1 each  APB completion/error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS.
  - PREADY=1 at the edge: capture rsp_rdata = PWRITE ? 0 : PRDATA, and rsp_err = PSLVERR; go to RESP.
  - PREADY=0: increment the wait counter.
  - Wait counter reaches TIMEOUT with PREADY still 0: rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - rsp_* held stable until rsp_ready.
  - On rsp_ready go to IDLE.
- PREADY, PRDATA and PSLVERR are sampled only in ACCESS and ignored elsewhere, so a PREADY still high after a transfer ends is harmless.
- Exactly one outstanding command; cmd_ready=0 in SETUP, ACCESS and RESP.
- Wait counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entering ACCESS.
  - Saturating, never wraps.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and rsp_timeout are all 0.
  - cmd_ready is a registered flag: 0 in reset, 1 from the first edge after release.
- Command accepted at edge E0:
  - SETUP in cycle E0→E1.
  - ACCESS from E1.
  - Zero-wait slave (PREADY=1 at E2): rsp_valid high from E2.
- Slave with registered PREADY (asserts one cycle after sampling PSEL&PENABLE): PREADY sampled at E3, rsp_valid from E3.
- rsp_ready high in the first RESP cycle: IDLE at the next edge. Next command is accepted at the earliest one edge later (minimum 4 cycles per zero-wait transfer).
- Timeout, TIMEOUT=N: abort at the edge ending the N-th consecutive PREADY-low ACCESS cycle.
- PRESETn asserted mid-transfer:
  - PSEL and PENABLE drop immediately (asynchronously).
  - The command is discarded and no response is produced.
- cmd_valid while busy: not accepted and no state change; the requester must hold it.

## Structure
- Package apb_pkg holds:
  - apb_state_e enum (IDLE, SETUP, ACCESS, RESP).
  - Default ADDR_W/DATA_W constants.
  - apb_cmd_t struct (write, addr, wdata) and apb_rsp_t struct (rdata, err, timeout), shared with the fabric and with apb_slave testbenches.
- One sub-module, apb_timeout_ctr:
  - Saturating counter with clear/enable.
  - Outputs the `expired` flag.
  - Instantiated only when TIMEOUT>0.

## Test plan
- Reset then write 0xDEADBEEF to 0x10 against a zero-wait model → SETUP/ACCESS each one cycle, PADDR/PWDATA stable, rsp_valid at E2, rsp_err=0, rsp_rdata=0.
- Write 0xA5A5A5A5 to 0x04, then read 0x04 against apb_slave → PREADY seen at E3, rsp_rdata=0xA5A5A5A5, rsp_err=0; PSEL low for at least 2 cycles between transfers.
- Read with 5 wait states then PSLVERR=1 → ACCESS held 6 cycles with stable PADDR; rsp_err=1, rsp_timeout=0.
- TIMEOUT=16 with PREADY tied 0 → abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL low next cycle.
- Hold rsp_ready=0 for 10 cycles with cmd_valid high → rsp_* stable, cmd_ready=0, no new SETUP; after rsp_ready, the next command is accepted.
- Assert PRESETn low during ACCESS → PSEL/PENABLE go 0 without a clock edge, rsp_valid stays 0; after release, cmd_ready=1 at the first edge.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ==================================================================
// apb_pkg : shared FSM, command and response types for APB masters
// rev 1.0
// ==================================================================
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ==================================================================
// apb_master_bridge_if : command/response ports plus APB3 bus signals
// rev 1.0
// ==================================================================
interface apb_master_bridge_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   // Bridge view: drives the APB request side and the response port.
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   // Environment view: requester plus APB slave.
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface
`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
`default_nettype none
// ==================================================================
// apb_timeout_ctr : saturating wait-state counter with clear/enable
// rev 1.0
// ==================================================================
module apb_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_clr,
   input  wire logic i_en,
   output logic      o_expired
);

   localparam int               CNT_W   = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != c_LIMIT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // High during the LIMIT-th waiting cycle: an abort taken at the end of
   // this cycle coincides with the count reaching LIMIT.
   assign o_expired = (r_cnt >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ==================================================================
// apb_master_bridge : single-outstanding command port to APB3 master
// rev 1.0
// ==================================================================
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  wire logic            PCLK,
   input  wire logic            PRESETn,
   apb_master_bridge_if.master  apb_bus
);

   apb_state_e        r_state;
   apb_state_e        w_next;

   logic              r_cmd_ready;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic              r_timeout;

   logic              w_accept;
   logic              w_done;
   logic              w_abort;
   logic              w_expired;
   logic              w_psel;
   logic              w_penable;
   logic              w_rsp_valid;
   logic              w_cnt_clr;
   logic              w_cnt_en;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_psel      = 1'b0;
      w_penable   = 1'b0;
      w_rsp_valid = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_cmd_ready && apb_bus.cmd_valid) begin
               w_accept = 1'b1;
               w_next   = SETUP;
            end
         end
         SETUP: begin
            w_psel = 1'b1;
            w_next = ACCESS;
         end
         ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
            if (apb_bus.PREADY) begin
               w_done = 1'b1;
               w_next = RESP;
            end else if (w_expired) begin
               w_abort = 1'b1;
               w_next  = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (apb_bus.rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Ready only in settled IDLE, so nothing is taken on the edge that leaves RESP.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_cmd_ready <= 1'b0;
      end else begin
         r_cmd_ready <= (w_next == IDLE);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
      end else if (w_accept) begin
         r_pwrite <= apb_bus.cmd_write;
         r_paddr  <= apb_bus.cmd_addr;
         r_pwdata <= apb_bus.cmd_wdata;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_done) begin
         r_rdata   <= r_pwrite ? '0 : apb_bus.PRDATA;
         r_err     <= apb_bus.PSLVERR;
         r_timeout <= 1'b0;
      end else if (w_abort) begin
         r_rdata   <= '0;
         r_err     <= 1'b1;
         r_timeout <= 1'b1;
      end
   end

   assign w_cnt_clr = (r_state == SETUP);
   assign w_cnt_en  = (r_state == ACCESS) && !apb_bus.PREADY;

   generate
      if (TIMEOUT > 0) begin : g_timeout
         apb_timeout_ctr #(
            .LIMIT (TIMEOUT)
         ) u_timeout_ctr (
            .clk       (PCLK),
            .rst_n     (PRESETn),
            .i_clr     (w_cnt_clr),
            .i_en      (w_cnt_en),
            .o_expired (w_expired)
         );
      end else begin : g_no_timeout
         assign w_expired = 1'b0;
      end
   endgenerate

   // Strobes decode straight from the state so reset removes them at once.
   assign apb_bus.PSEL        = w_psel;
   assign apb_bus.PENABLE     = w_penable;
   assign apb_bus.PWRITE      = r_pwrite;
   assign apb_bus.PADDR       = r_paddr;
   assign apb_bus.PWDATA      = r_pwdata;
   assign apb_bus.cmd_ready   = r_cmd_ready;
   assign apb_bus.rsp_valid   = w_rsp_valid;
   assign apb_bus.rsp_rdata   = r_rdata;
   assign apb_bus.rsp_err     = r_err;
   assign apb_bus.rsp_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ==================================================================
// tb_apb_master_bridge : directed bench with a transaction timeline model
// rev 1.0
// ==================================================================
module tb_apb_master_bridge;

   localparam int TO = 16;

   logic PCLK = 1'b0;
   logic PRESETn;
   always #5 PCLK = ~PCLK;

   apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master_bridge #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .apb_bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave behaviour knobs, set by the stimulus before each command.
   int   cfg_wait       = 0;
   logic cfg_err        = 1'b0;
   logic cfg_idle_ready = 1'b1;

   logic [31:0] smem [logic [31:0]];
   int          acc_cnt = 0;

   // APB slave: PREADY after cfg_wait low ACCESS cycles; outside ACCESS it
   // drives noisy PREADY/PSLVERR that the bridge must ignore.
   always @(negedge PCLK) begin
      if (bus.PSEL && bus.PENABLE) begin
         if (acc_cnt == cfg_wait) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = cfg_err;
            if (!bus.PWRITE) begin
               bus.PRDATA = smem.exists(bus.PADDR) ? smem[bus.PADDR] : 32'h0;
            end else if (!cfg_err) begin
               smem[bus.PADDR] = bus.PWDATA;
            end
         end else begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b1;
            bus.PRDATA  = 32'hBAD0BAD0;
         end
         acc_cnt++;
      end else begin
         acc_cnt     = 0;
         bus.PREADY  = cfg_idle_ready;
         bus.PSLVERR = cfg_idle_ready;
         bus.PRDATA  = 32'hBAD0BAD0;
      end
   end

   // Model: a transfer accepted at edge E0 is SETUP for one cycle, ACCESS for
   // m_len cycles, then responds until rsp_ready is seen at an edge.
   bit          m_busy, m_rdy;
   int          m_n, m_len;
   logic        m_pwrite, m_err, m_to;
   logic [31:0] m_paddr, m_pwdata, m_rdata;
   logic [31:0] mmem [logic [31:0]];

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m_busy = 1'b0;
         m_rdy  = 1'b0;
      end else if (m_busy) begin
         if (m_n > m_len && bus.rsp_ready) begin
            m_busy = 1'b0;
            m_rdy  = 1'b1;
         end else begin
            m_n++;
         end
      end else if (m_rdy && bus.cmd_valid) begin
         m_busy   = 1'b1;
         m_rdy    = 1'b0;
         m_n      = 0;
         m_pwrite = bus.cmd_write;
         m_paddr  = bus.cmd_addr;
         m_pwdata = bus.cmd_wdata;
         if (TO > 0 && cfg_wait >= TO) begin
            m_len   = TO;
            m_rdata = 32'h0;
            m_err   = 1'b1;
            m_to    = 1'b1;
         end else begin
            m_len   = cfg_wait + 1;
            m_err   = cfg_err;
            m_to    = 1'b0;
            m_rdata = m_pwrite ? 32'h0 : (mmem.exists(m_paddr) ? mmem[m_paddr] : 32'h0);
            if (m_pwrite && !cfg_err) mmem[m_paddr] = m_pwdata;
         end
      end else begin
         m_rdy = 1'b1;
      end
   end

   always @(negedge PCLK) begin : cmp
      bit e_psel, e_pen, e_rv;
      if (started) begin
         e_psel = m_busy && (m_n <= m_len);
         e_pen  = m_busy && (m_n >= 1) && (m_n <= m_len);
         e_rv   = m_busy && (m_n > m_len);
         check("cmd_ready", bus.cmd_ready, m_rdy);
         check("PSEL", bus.PSEL, e_psel);
         check("PENABLE", bus.PENABLE, e_pen);
         check("rsp_valid", bus.rsp_valid, e_rv);
         if (e_psel) begin
            check("PADDR", bus.PADDR, m_paddr);
            check("PWRITE", bus.PWRITE, m_pwrite);
            check("PWDATA", bus.PWDATA, m_pwdata);
         end
         if (e_rv) begin
            check("rsp_rdata", bus.rsp_rdata, m_rdata);
            check("rsp_err", bus.rsp_err, m_err);
            check("rsp_timeout", bus.rsp_timeout, m_to);
         end
      end
   end

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int k = 0;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      bus.cmd_valid = 1'b1;
      while (bus.cmd_ready !== 1'b1 && k < 50) begin
         @(negedge PCLK);
         k++;
      end
      check("cmd_accepted", (k < 50), 1'b1);
      @(posedge PCLK);
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er, output logic tmo);
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 100) begin
         @(negedge PCLK);
         lat++;
      end
      rd  = bus.rsp_rdata;
      er  = bus.rsp_err;
      tmo = bus.rsp_timeout;
   endtask

   task automatic release_rsp(input int hold);
      repeat (hold) @(negedge PCLK);
      bus.rsp_ready = 1'b1;
      @(negedge PCLK);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er, tmo;

      PRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h0;
      bus.cmd_wdata = 32'h0;
      bus.rsp_ready = 1'b0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      bus.PRDATA    = 32'h0;
      repeat (3) @(negedge PCLK);

      check("rst_PSEL", bus.PSEL, 1'b0);
      check("rst_PENABLE", bus.PENABLE, 1'b0);
      check("rst_PWRITE", bus.PWRITE, 1'b0);
      check("rst_PADDR", bus.PADDR, 32'h0);
      check("rst_PWDATA", bus.PWDATA, 32'h0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_err", bus.rsp_err, 1'b0);
      check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);

      started = 1'b1;
      PRESETn = 1'b1;
      @(negedge PCLK);
      check("cmd_ready_after_release", bus.cmd_ready, 1'b1);

      // Zero-wait write.
      cfg_wait = 0; cfg_err = 1'b0;
      send(1'b1, 32'h10, 32'hDEADBEEF);
      wait_rsp(lat, rd, er, tmo);
      check("t1_latency", lat, 2);
      check("t1_rdata", rd, 32'h0);
      check("t1_err", er, 1'b0);
      check("t1_timeout", tmo, 1'b0);
      release_rsp(0);

      // Registered-PREADY slave: write then read back.
      cfg_wait = 1;
      send(1'b1, 32'h04, 32'hA5A5A5A5);
      wait_rsp(lat, rd, er, tmo);
      check("t2w_latency", lat, 3);
      release_rsp(0);
      send(1'b0, 32'h04, 32'h0);
      wait_rsp(lat, rd, er, tmo);
      check("t2r_latency", lat, 3);
      check("t2r_rdata", rd, 32'hA5A5A5A5);
      check("t2r_err", er, 1'b0);
      release_rsp(0);

      // Five wait states ending in PSLVERR.
      cfg_wait = 5; cfg_err = 1'b1;
      send(1'b0, 32'h10, 32'h0);
      wait_rsp(lat, rd, er, tmo);
      check("t3_latency", lat, 7);
      check("t3_rdata", rd, 32'hDEADBEEF);
      check("t3_err", er, 1'b1);
      check("t3_timeout", tmo, 1'b0);
      release_rsp(1);
      cfg_err = 1'b0;

      // PREADY tied low: abort after TO ACCESS cycles.
      cfg_wait = 1000; cfg_idle_ready = 1'b0;
      send(1'b0, 32'h20, 32'h0);
      wait_rsp(lat, rd, er, tmo);
      check("t4_latency", lat, 17);
      check("t4_rdata", rd, 32'h0);
      check("t4_err", er, 1'b1);
      check("t4_timeout", tmo, 1'b1);
      check("t4_psel_after", bus.PSEL, 1'b0);
      release_rsp(0);
      cfg_wait = 0; cfg_idle_ready = 1'b1;

      // Response back-pressure with the next command already presented.
      send(1'b1, 32'h08, 32'h12345678);
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h08;
      bus.cmd_valid = 1'b1;
      wait_rsp(lat, rd, er, tmo);
      check("t5w_latency", lat, 2);
      repeat (10) @(negedge PCLK);
      check("t5_hold_rsp_valid", bus.rsp_valid, 1'b1);
      check("t5_hold_cmd_ready", bus.cmd_ready, 1'b0);
      check("t5_hold_psel", bus.PSEL, 1'b0);
      release_rsp(0);
      send(1'b0, 32'h08, 32'h0);
      wait_rsp(lat, rd, er, tmo);
      check("t5r_latency", lat, 2);
      check("t5r_rdata", rd, 32'h12345678);
      release_rsp(0);

      // Reset asserted in the middle of ACCESS.
      cfg_wait = 1000;
      send(1'b0, 32'h30, 32'h0);
      @(negedge PCLK);
      check("t6_in_access", bus.PENABLE, 1'b1);
      #2 PRESETn = 1'b0;
      #1;
      check("t6_async_psel", bus.PSEL, 1'b0);
      check("t6_async_penable", bus.PENABLE, 1'b0);
      @(negedge PCLK);
      check("t6_no_rsp", bus.rsp_valid, 1'b0);
      @(negedge PCLK);
      cfg_wait = 0;
      PRESETn  = 1'b1;
      check("t6_ready_in_release", bus.cmd_ready, 1'b0);
      @(negedge PCLK);
      check("t6_ready_first_edge", bus.cmd_ready, 1'b1);

      // Normal traffic after reset, two wait states on the read.
      send(1'b1, 32'h40, 32'hCAFEF00D);
      wait_rsp(lat, rd, er, tmo);
      check("t7w_latency", lat, 2);
      release_rsp(0);
      cfg_wait = 2;
      send(1'b0, 32'h40, 32'h0);
      wait_rsp(lat, rd, er, tmo);
      check("t7r_latency", lat, 4);
      check("t7r_rdata", rd, 32'hCAFEF00D);
      release_rsp(0);

      repeat (3) @(negedge PCLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
